// File: rtl/alu_exec_mem.sv
// alu_exec_mem: execute-stage ALU with its control decoder plus a small
// word-addressed data memory. The ALU result doubles as the byte address.
// Optional feature macro: ALU_OVERFLOW_EN adds a signed-overflow output
// for ADD/SUB.
module alu_exec_mem #(
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  alu_op,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_wdata,
   output logic [3:0]  alu_ctrl,
   output logic        jump_reg,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] mem_rdata
`ifdef ALU_OVERFLOW_EN
   ,
   output logic        overflow
`endif
);

   localparam int AW = $clog2(DMEM_WORDS);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_XOR  = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_LUI  = 4'b1101;

   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic [31:0]        sum;
   logic [31:0]        diff;
   logic [AW-1:0]      idx;
   logic [31:0]        mem_q [DMEM_WORDS];
   logic [31:0]        mem_d [DMEM_WORDS];

   assign a_s  = src_a;
   assign b_s  = src_b;
   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;

   // Decode main-control class and R-type funct into an ALU operation.
   always_comb begin
      alu_ctrl = OP_ADD;
      jump_reg = 1'b0;
      case (alu_op)
         3'b000: alu_ctrl = OP_ADD;
         3'b001: alu_ctrl = OP_SUB;
         3'b011: alu_ctrl = OP_AND;
         3'b100: alu_ctrl = OP_OR;
         3'b101: alu_ctrl = OP_SLT;
         3'b110: alu_ctrl = OP_LUI;
         3'b111: alu_ctrl = OP_XOR;
         default: begin
            // R-type: unlisted funct codes fall back to ADD
            case (funct)
               6'b100000, 6'b100001: alu_ctrl = OP_ADD;
               6'b100010, 6'b100011: alu_ctrl = OP_SUB;
               6'b100100: alu_ctrl = OP_AND;
               6'b100101: alu_ctrl = OP_OR;
               6'b100110: alu_ctrl = OP_XOR;
               6'b100111: alu_ctrl = OP_NOR;
               6'b101010: alu_ctrl = OP_SLT;
               6'b101011: alu_ctrl = OP_SLTU;
               6'b000000: alu_ctrl = OP_SLL;
               6'b000010: alu_ctrl = OP_SRL;
               6'b000011: alu_ctrl = OP_SRA;
               6'b001000: begin
                  alu_ctrl = OP_ADD;
                  jump_reg = 1'b1;
               end
               default: alu_ctrl = OP_ADD;
            endcase
         end
      endcase
   end

   // ALU datapath; shifts and LUI use only src_b, unused codes yield 0.
   always_comb begin
      alu_result = 32'h0;
      case (alu_ctrl)
         OP_AND:  alu_result = src_a & src_b;
         OP_OR:   alu_result = src_a | src_b;
         OP_ADD:  alu_result = sum;
         OP_SUB:  alu_result = diff;
         OP_XOR:  alu_result = src_a ^ src_b;
         OP_NOR:  alu_result = ~(src_a | src_b);
         OP_SLT:  alu_result = {31'h0, (a_s < b_s)};
         OP_SLTU: alu_result = {31'h0, (src_a < src_b)};
         OP_SLL:  alu_result = src_b << shamt;
         OP_SRL:  alu_result = src_b >> shamt;
         OP_SRA:  alu_result = $unsigned(b_s >>> shamt);
         OP_LUI:  alu_result = {src_b[15:0], 16'h0000};
         default: alu_result = 32'h0;
      endcase
   end

   assign zero = (alu_result == 32'h0);

`ifdef ALU_OVERFLOW_EN
   // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
   // result sign departs from src_a.
   always_comb begin
      overflow = 1'b0;
      if (alu_ctrl == OP_ADD)
         overflow = (src_a[31] == src_b[31]) && (sum[31] != src_a[31]);
      else if (alu_ctrl == OP_SUB)
         overflow = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
   end
`endif

   // Byte address wraps: only the word-index bits select a location.
   assign idx = alu_result[AW+1:2];

   // Next memory image: one word replaced when a store is requested.
   always_comb begin
      mem_d = mem_q;
      if (mem_write)
         mem_d[idx] = mem_wdata;
   end

   // Memory array; reset clears every word immediately and blocks stores.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DMEM_WORDS; i++)
            mem_q[i] <= 32'h0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Combinational load port, forced to 0 when not reading or in reset.
   always_comb begin
      mem_rdata = 32'h0;
      if (mem_read && !rst)
         mem_rdata = mem_q[idx];
   end

endmodule

// File: tb/tb_alu_exec_mem.sv
// Directed self-checking bench for alu_exec_mem.
module tb_alu_exec_mem;

   logic        clk;
   logic        rst;
   logic [2:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [3:0]  alu_ctrl;
   logic        jump_reg;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] mem_rdata;
`ifdef ALU_OVERFLOW_EN
   logic        overflow;
`endif

   int errors = 0;
   int checks = 0;

   alu_exec_mem #(.DMEM_WORDS(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_op     (alu_op),
      .funct      (funct),
      .shamt      (shamt),
      .src_a      (src_a),
      .src_b      (src_b),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_wdata  (mem_wdata),
      .alu_ctrl   (alu_ctrl),
      .jump_reg   (jump_reg),
      .alu_result (alu_result),
      .zero       (zero),
      .mem_rdata  (mem_rdata)
`ifdef ALU_OVERFLOW_EN
      ,
      .overflow   (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic set_alu(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b);
      alu_op = op;
      funct  = fn;
      shamt  = sh;
      src_a  = a;
      src_b  = b;
      #1;
   endtask

   initial begin
      rst = 1'b0; alu_op = 3'b000; funct = 6'h0; shamt = 5'h0;
      src_a = 32'h0; src_b = 32'h0;
      mem_read = 1'b0; mem_write = 1'b0; mem_wdata = 32'h0;
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      // reset state: memory reads 0 and ALU still works under reset
      mem_read = 1'b1;
      set_alu(3'b000, 6'h00, 5'd0, 32'h0, 32'h14);
      check_val("rst_rdata", mem_rdata, 32'h0);
      set_alu(3'b000, 6'h00, 5'd0, 32'h3, 32'h4);
      check_val("rst_alu_add", alu_result, 32'h7);
      check_val("rst_zero", {31'h0, zero}, 32'h0);
      mem_read = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // R-type SUB to zero
      set_alu(3'b010, 6'b100010, 5'd0, 32'd5, 32'd5);
      check_val("sub_ctrl", {28'h0, alu_ctrl}, 32'h6);
      check_val("sub_res", alu_result, 32'h0);
      check_val("sub_zero", {31'h0, zero}, 32'h1);
      // signed vs unsigned compare
      set_alu(3'b010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1);
      check_val("slt", alu_result, 32'h1);
      set_alu(3'b010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'h1);
      check_val("sltu", alu_result, 32'h0);
      check_val("sltu_zero", {31'h0, zero}, 32'h1);
      // shifts
      set_alu(3'b010, 6'b000000, 5'd4, 32'hFFFFFFFF, 32'h0000000F);
      check_val("sll", alu_result, 32'h000000F0);
      set_alu(3'b010, 6'b000011, 5'd4, 32'h0, 32'h80000000);
      check_val("sra", alu_result, 32'hF8000000);
      set_alu(3'b010, 6'b000010, 5'd4, 32'h0, 32'h80000000);
      check_val("srl", alu_result, 32'h08000000);
      // JR
      set_alu(3'b010, 6'b001000, 5'd0, 32'h100, 32'h0);
      check_val("jr_flag", {31'h0, jump_reg}, 32'h1);
      check_val("jr_ctrl", {28'h0, alu_ctrl}, 32'h2);
      // NOR, unlisted funct
      set_alu(3'b010, 6'b100111, 5'd0, 32'hF0F0F0F0, 32'h0F0F0000);
      check_val("nor", alu_result, 32'h00000F0F);
      check_val("nor_ctrl", {28'h0, alu_ctrl}, 32'hC);
      set_alu(3'b010, 6'h3F, 5'd0, 32'h10, 32'h22);
      check_val("unl_ctrl", {28'h0, alu_ctrl}, 32'h2);
      check_val("unl_jr", {31'h0, jump_reg}, 32'h0);
      check_val("unl_res", alu_result, 32'h32);
      // direct alu_op classes
      set_alu(3'b110, 6'h0, 5'd0, 32'h0000FFFF, 32'h00001234);
      check_val("lui", alu_result, 32'h12340000);
      set_alu(3'b111, 6'h0, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
      check_val("xor", alu_result, 32'hF0F0F0F0);
      set_alu(3'b011, 6'h0, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
      check_val("and", alu_result, 32'h0F000F00);
      set_alu(3'b100, 6'h0, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
      check_val("or", alu_result, 32'hFFF0FFF0);
      set_alu(3'b001, 6'h0, 5'd0, 32'd3, 32'd5);
      check_val("sub_neg", alu_result, 32'hFFFFFFFE);
      check_val("sub_neg_zero", {31'h0, zero}, 32'h0);
      set_alu(3'b101, 6'h0, 5'd0, 32'h80000000, 32'h7FFFFFFF);
      check_val("slt_op", alu_result, 32'h1);
      set_alu(3'b000, 6'h0, 5'd0, 32'hFFFFFFFF, 32'h1);
      check_val("add_wrap", alu_result, 32'h0);
      check_val("add_wrap_zero", {31'h0, zero}, 32'h1);
`ifdef ALU_OVERFLOW_EN
      set_alu(3'b000, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1);
      check_val("ovf_add", {31'h0, overflow}, 32'h1);
      check_val("ovf_add_res", alu_result, 32'h80000000);
      set_alu(3'b011, 6'h0, 5'd0, 32'h7FFFFFFF, 32'h1);
      check_val("ovf_and", {31'h0, overflow}, 32'h0);
      set_alu(3'b001, 6'h0, 5'd0, 32'h80000000, 32'h1);
      check_val("ovf_sub", {31'h0, overflow}, 32'h1);
`endif

      // store DEADBEEF to byte address 0x14
      set_alu(3'b000, 6'h0, 5'd0, 32'h10, 32'h4);
      mem_write = 1'b1; mem_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      mem_write = 1'b0;
      mem_read = 1'b1; #1;
      check_val("ld_after_st", mem_rdata, 32'hDEADBEEF);
      mem_read = 1'b0; #1;
      check_val("ld_disabled", mem_rdata, 32'h0);
      // wrap and ignored low bits
      mem_read = 1'b1;
      set_alu(3'b000, 6'h0, 5'd0, 32'h110, 32'h7);
      check_val("ld_wrap", mem_rdata, 32'hDEADBEEF);
      set_alu(3'b000, 6'h0, 5'd0, 32'h10, 32'h0);
      check_val("ld_other", mem_rdata, 32'h0);
      // read-during-write: old value before the edge, new after
      set_alu(3'b000, 6'h0, 5'd0, 32'h10, 32'h4);
      @(negedge clk);
      mem_write = 1'b1; mem_wdata = 32'hCAFEF00D; #1;
      check_val("rdw_old", mem_rdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      check_val("rdw_new", mem_rdata, 32'hCAFEF00D);
      mem_write = 1'b0;

      // asynchronous reset pulse between edges
      @(negedge clk); #2;
      rst = 1'b1; #1;
      rst = 1'b0; #1;
      check_val("async_clr", mem_rdata, 32'h0);
      // store attempted while reset is held is lost
      @(negedge clk);
      rst = 1'b1;
      mem_write = 1'b1; mem_wdata = 32'h12345678;
      @(posedge clk); #1;
      check_val("rst_rd_zero", mem_rdata, 32'h0);
      mem_write = 1'b0; #1;
      rst = 1'b0; #1;
      check_val("rst_wr_lost", mem_rdata, 32'h0);
      mem_read = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
